mux_scan_sequencer: RTL and testbench

- Drives the 8-to-1 multiplexer stage directly upstream of it.
- Accepts an 8-bit word on a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through all 8 positions, holding each for DIV clocks. This serialises the word.
- Samples the mux output back at the end of every bit slot and rebuilds the word. It then flags any mismatch as a loopback check of the mux stage.

---
 rtl/mux_scan_sequencer_pkg.sv | 28 ++
 rtl/mux_scan_sequencer_slot_timer.sv | 42 ++++
 rtl/mux_scan_sequencer.sv | 117 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer.
//   - FSM state encodings (IDLE / SCAN)
//   - Mux geometry: MUX_WIDTH data inputs, SEL_W select bits
//   - insert_bit(): rebuilds a word one sampled bit at a time
package mux_scan_sequencer_pkg;

  localparam int MUX_WIDTH = 8;
  localparam int SEL_W     = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  // Index of the last bit slot in a scan.
  localparam logic [SEL_W-1:0] LAST_BIT = 3'd7;

  // Returns word with bit position pos replaced by value b.
  function automatic logic [MUX_WIDTH-1:0] insert_bit(
    input logic [MUX_WIDTH-1:0] word,
    input logic [SEL_W-1:0]     pos,
    input logic                 b
  );
    logic [MUX_WIDTH-1:0] res;
    res      = word;
    res[pos] = b;
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_slot_timer.sv
// DIV-modulo slot counter for the mux scan sequencer.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   clear    in   synchronous clear (word accept or abort)
//   run      in   count enable (high while scanning)
//   slot_end out  high in the last clock of each DIV-clock slot
module mux_scan_sequencer_slot_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic slot_end
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] count;

  // With DIV = 1 LAST is 0, so every running clock is a slot end.
  assign slot_end = run && (count == LAST);

  // Slot counter: clears on request, wraps at the end of every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (run) begin
      if (slot_end) begin
        count <= 16'd0;
      end else begin
        count <= count + 16'd1;
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Serialises an 8-bit word through an upstream 8-to-1 mux by stepping its
// select, samples the mux output at the end of every bit slot, rebuilds the
// word and flags a loopback mismatch.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  word handshake; in_data word, msb_first order select
//   abort              cancels a running scan (no done pulse)
//   mux_data/sel/en    drive the mux; mux_out is the mux output returned
//   busy               scan in progress; done one-cycle completion pulse
//   loop_word          rebuilt word; loop_err sticky mismatch flag
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MUX_WIDTH-1:0] in_data,
  input  logic                 msb_first,
  input  logic                 abort,
  output logic [MUX_WIDTH-1:0] mux_data,
  output logic [SEL_W-1:0]     mux_sel,
  output logic                 mux_en,
  input  logic                 mux_out,
  output logic                 busy,
  output logic                 done,
  output logic [MUX_WIDTH-1:0] loop_word,
  output logic                 loop_err
);

  logic [0:0]           state;
  logic                 msb_r;
  logic [SEL_W-1:0]     bit_cnt;
  logic                 accept;
  logic                 timer_clear;
  logic                 slot_end;
  logic [MUX_WIDTH-1:0] word_next;

  assign in_ready    = (state == IDLE) && !rst;
  assign accept      = in_valid && in_ready;
  assign timer_clear = accept || ((state == SCAN) && abort);

  // Word including the sample being taken this cycle, so the final compare
  // sees the last bit.
  assign word_next = insert_bit(loop_word, mux_sel, mux_out);

  mux_scan_sequencer_slot_timer #(.DIV(DIV)) u_slot_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .run      (state == SCAN),
    .slot_end (slot_end)
  );

  // Scan FSM: accept, step the select per slot, sample and finish or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      msb_r     <= 1'b0;
      bit_cnt   <= 3'd0;
      mux_data  <= 8'h00;
      mux_sel   <= 3'd0;
      mux_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      loop_word <= 8'h00;
      loop_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Accept wins over a simultaneous abort, which is ignored in IDLE.
          if (accept) begin
            state     <= SCAN;
            mux_data  <= in_data;
            msb_r     <= msb_first;
            mux_sel   <= msb_first ? 3'd7 : 3'd0;
            mux_en    <= 1'b1;
            busy      <= 1'b1;
            bit_cnt   <= 3'd0;
            loop_word <= 8'h00;
            loop_err  <= 1'b0;
          end
        end
        SCAN: begin
          if (abort) begin
            // Partial loop_word / loop_err are left for inspection.
            state  <= IDLE;
            mux_en <= 1'b0;
            busy   <= 1'b0;
          end else if (slot_end) begin
            loop_word <= word_next;
            if (bit_cnt != LAST_BIT) begin
              bit_cnt <= bit_cnt + 3'd1;
              mux_sel <= msb_r ? (mux_sel - 3'd1) : (mux_sel + 3'd1);
            end else begin
              // mux_sel and mux_data keep their last values.
              state    <= IDLE;
              mux_en   <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              loop_err <= (word_next != mux_data);
            end
          end
        end
        default: begin
          state  <= IDLE;
          mux_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: one instance with DIV = 4 and
// one with DIV = 1, each looped back through a behavioural 8-to-1 mux with an
// optional stuck-at-0 fault on one position.
module tb_mux_scan_sequencer;

  typedef struct {
    int         u;
    logic [7:0] data;
    logic       msb;
    int         fault;
    logic [7:0] exp_word;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] word;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic       msb_first [2];
  logic       abort     [2];
  logic [7:0] mux_data  [2];
  logic [2:0] mux_sel   [2];
  logic       mux_en    [2];
  logic       mux_out   [2];
  logic       busy      [2];
  logic       done      [2];
  logic [7:0] loop_word [2];
  logic       loop_err  [2];
  int         fault_pos [2];

  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t vecs[7];

  mux_scan_sequencer #(.DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .msb_first(msb_first[0]), .abort(abort[0]),
    .mux_data(mux_data[0]), .mux_sel(mux_sel[0]), .mux_en(mux_en[0]),
    .mux_out(mux_out[0]), .busy(busy[0]), .done(done[0]),
    .loop_word(loop_word[0]), .loop_err(loop_err[0])
  );

  mux_scan_sequencer #(.DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .msb_first(msb_first[1]), .abort(abort[1]),
    .mux_data(mux_data[1]), .mux_sel(mux_sel[1]), .mux_en(mux_en[1]),
    .mux_out(mux_out[1]), .busy(busy[1]), .done(done[1]),
    .loop_word(loop_word[1]), .loop_err(loop_err[1])
  );

  // Behavioural mux with an optional stuck-at-0 position.
  assign mux_out[0] = mux_en[0] && (int'(mux_sel[0]) != fault_pos[0]) && mux_data[0][mux_sel[0]];
  assign mux_out[1] = mux_en[1] && (int'(mux_sel[1]) != fault_pos[1]) && mux_data[1][mux_sel[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the completed word.
  task automatic sb_check(input int u);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow actual=empty required=entry");
    end else begin
      e = sb.pop_front();
      chk("loop_word", 32'(loop_word[u]), 32'(e.word));
      chk("loop_err", 32'(loop_err[u]), 32'(e.err));
    end
  endtask

  // Waits (bounded) for done on instance u; returns cycles since accept.
  task automatic wait_done(input int u, input int div, input logic msb, output int n,
                           output bit sel_ok, output bit en_ok);
    logic [2:0] exp_sel;
    int j;
    n = 1;
    sel_ok = 1'b1;
    en_ok = 1'b1;
    while (!done[u] && n <= 8 * div + 5) begin
      if (n <= 8 * div) begin
        if (mux_en[u] !== 1'b1) en_ok = 1'b0;
        if ((n - 1) % div == 0) begin
          j = (n - 1) / div;
          exp_sel = msb ? 3'(7 - j) : 3'(j);
          if (mux_sel[u] !== exp_sel) sel_ok = 1'b0;
        end
      end
      tick();
      n++;
    end
  endtask

  // Full accept-to-done transaction on instance u.
  task automatic run_word(input int u, input logic [7:0] data, input logic msb,
                          input int fault, input logic [7:0] ew, input logic ee);
    int div;
    int n;
    bit sel_ok;
    bit en_ok;
    exp_t e;
    div = (u == 0) ? 4 : 1;
    chk("ready_idle", 32'(in_ready[u]), 32'd1);
    fault_pos[u] = fault;
    in_valid[u]  = 1'b1;
    in_data[u]   = data;
    msb_first[u] = msb;
    tick();
    in_valid[u] = 1'b0;
    e.word = ew;
    e.err  = ee;
    sb.push_back(e);
    chk("capture_data", 32'(mux_data[u]), 32'(data));
    chk("accept_clr_word", 32'(loop_word[u]), 32'd0);
    chk("accept_clr_err", 32'(loop_err[u]), 32'd0);
    chk("busy_scan", 32'(busy[u]), 32'd1);
    wait_done(u, div, msb, n, sel_ok, en_ok);
    chk("done_latency", 32'(n), 32'(8 * div + 1));
    chk("sel_sequence", 32'(sel_ok), 32'd1);
    chk("en_window", 32'(en_ok), 32'd1);
    chk("done_ready", 32'(in_ready[u]), 32'd1);
    chk("done_en_low", 32'(mux_en[u]), 32'd0);
    chk("done_busy_low", 32'(busy[u]), 32'd0);
    sb_check(u);
    tick();
    chk("done_one_cycle", 32'(done[u]), 32'd0);
    fault_pos[u] = -1;
  endtask

  initial begin
    int n;
    bit sel_ok;
    bit en_ok;
    bit saw_done;
    exp_t e;

    checks   = 0;
    failures = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      msb_first[i] = 1'b0;
      abort[i]     = 1'b0;
      fault_pos[i] = -1;
    end

    vecs[0] = '{0, 8'h5A, 1'b0, -1, 8'h5A, 1'b0};
    vecs[1] = '{1, 8'hC3, 1'b1, -1, 8'hC3, 1'b0};
    vecs[2] = '{0, 8'hFF, 1'b0,  3, 8'hF7, 1'b1};
    vecs[3] = '{0, 8'h3C, 1'b1, -1, 8'h3C, 1'b0};
    vecs[4] = '{1, 8'h96, 1'b0,  4, 8'h86, 1'b1};
    vecs[5] = '{1, 8'hA5, 1'b0, -1, 8'hA5, 1'b0};
    vecs[6] = '{0, 8'h00, 1'b1, -1, 8'h00, 1'b0};

    // Reset state.
    tick();
    tick();
    chk("rst_ready", 32'(in_ready[0]), 32'd0);
    chk("rst_en", 32'(mux_en[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_data", 32'(mux_data[0]), 32'd0);
    chk("rst_sel", 32'(mux_sel[0]), 32'd0);
    chk("rst_word", 32'(loop_word[0]), 32'd0);
    chk("rst_err", 32'(loop_err[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready[0]), 32'd1);
    tick();

    // Reset mid-scan, cycle 10 after accept.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h5A;
    tick();
    in_valid[0] = 1'b0;
    n = 1;
    while (n < 10) begin
      tick();
      n++;
    end
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_en", 32'(mux_en[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_sel", 32'(mux_sel[0]), 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_ready_release", 32'(in_ready[0]), 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) saw_done = 1'b1;
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);

    // Table of loopback transactions.
    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].u, vecs[i].data, vecs[i].msb, vecs[i].fault,
               vecs[i].exp_word, vecs[i].exp_err);
    end

    // Abort together with the slot end of bit 2.
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'hA5;
    msb_first[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    n = 1;
    while (n < 12) begin
      tick();
      n++;
    end
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_en", 32'(mux_en[0]), 32'd0);
    chk("abort_done", 32'(done[0]), 32'd0);
    chk("abort_word", 32'(loop_word[0]), 32'h01);
    chk("abort_err", 32'(loop_err[0]), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done[0] === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    run_word(0, 8'h69, 1'b0, -1, 8'h69, 1'b0);

    // Back-to-back: in_valid held, second accept in the done cycle.
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'h11;
    msb_first[0] = 1'b0;
    tick();
    in_data[0] = 8'h22;
    e.word = 8'h11;
    e.err  = 1'b0;
    sb.push_back(e);
    wait_done(0, 4, 1'b0, n, sel_ok, en_ok);
    chk("b2b_first_latency", 32'(n), 32'd33);
    chk("b2b_ready_in_done", 32'(in_ready[0]), 32'd1);
    sb_check(0);
    tick();
    in_valid[0] = 1'b0;
    e.word = 8'h22;
    sb.push_back(e);
    chk("b2b_no_gap_busy", 32'(busy[0]), 32'd1);
    chk("b2b_second_data", 32'(mux_data[0]), 32'h22);
    chk("b2b_done_cleared", 32'(done[0]), 32'd0);
    wait_done(0, 4, 1'b0, n, sel_ok, en_ok);
    chk("b2b_second_latency", 32'(n), 32'd33);
    chk("b2b_sel_sequence", 32'(sel_ok), 32'd1);
    sb_check(0);
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
